// File: rtl/pair_sched.sv
// pair_sched: enumerates every unordered point pair (a,b), a<b, for one solver
// run and issues them to the distance unit over valid/ready, bounding the
// number of pairs in flight and raising dist_done once every result is back.
// Optional build macro: PAIR_SCHED_PERF_EN enables the stall_cycles counter;
// when undefined stall_cycles is tied to zero.
module pair_sched #(
    parameter int NUM_POINTS = 1000,
    parameter int MAX_OUT    = 8,
    localparam int IDX_W     = $clog2(NUM_POINTS),
    localparam int NPTS_W    = $clog2(NUM_POINTS + 1),
    localparam int PAIR_W    = $clog2(NUM_POINTS * (NUM_POINTS - 1) / 2 + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NPTS_W-1:0] num_pts,
    output logic              busy,
    output logic [IDX_W-1:0]  pair_a,
    output logic [IDX_W-1:0]  pair_b,
    output logic              pair_vld,
    input  logic              pair_rdy,
    input  logic              res_vld,
    output logic              dist_done,
    output logic [PAIR_W-1:0] pairs_issued,
    output logic              err_unexp,
    output logic [31:0]       stall_cycles
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NPTS_W-1:0]  n_q;
    logic [IDX_W-1:0]   a_q, b_q;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [PAIR_W-1:0]  issued_q;
    logic               err_q;

    logic               start_ok;
    logic [NPTS_W-1:0]  n_clamp;
    logic               vld;
    logic               xfer;
    logic               res_ok;
    logic               last_b;
    logic               last_pair;

    // Handshake, outstanding bookkeeping and pair-position decode
    always_comb begin
        start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
        n_clamp   = (num_pts > NPTS_W'(NUM_POINTS)) ? NPTS_W'(NUM_POINTS) : num_pts;
        vld       = (state_q == ISSUE) && (out_q < OUT_W'(MAX_OUT));
        xfer      = vld && pair_rdy;
        // a result with nothing outstanding only counts if a pair leaves this same cycle
        res_ok    = res_vld && ((out_q != '0) || xfer);
        out_d     = out_q + OUT_W'(xfer) - OUT_W'(res_ok);
        last_b    = (NPTS_W'(b_q) == (n_q - 1'b1));
        last_pair = last_b && (NPTS_W'(a_q) == (n_q - 2'd2));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_d = (n_clamp < NPTS_W'(2)) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (xfer && last_pair) begin
                    state_d = (out_d != '0) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (out_d == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Run parameters, pair walker, outstanding and issued counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            issued_q <= '0;
        end else if (start_ok) begin
            n_q      <= n_clamp;
            a_q      <= '0;
            b_q      <= IDX_W'(1);
            out_q    <= '0;
            issued_q <= '0;
        end else begin
            out_q <= out_d;
            if (xfer) begin
                issued_q <= issued_q + PAIR_W'(1);
                // the final pair is left on the bus rather than stepping past n-1
                if (!last_pair) begin
                    if (last_b) begin
                        a_q <= a_q + IDX_W'(1);
                        b_q <= a_q + IDX_W'(2);
                    end else begin
                        b_q <= b_q + IDX_W'(1);
                    end
                end
            end
        end
    end

    // Sticky flag for results arriving when none are owed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (res_vld && (out_q == '0) && !xfer) begin
            err_q <= 1'b1;
        end
    end

`ifdef PAIR_SCHED_PERF_EN
    logic [31:0] stall_q;

    // Saturating count of ISSUE cycles lost to backpressure or the in-flight cap
    always_ff @(posedge clk) begin
        if (!rst_n || start_ok) begin
            stall_q <= '0;
        end else if ((state_q == ISSUE) && ((vld && !pair_rdy) || (out_q == OUT_W'(MAX_OUT)))
                     && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
    assign dist_done    = (state_q == DONE);
    assign pair_vld     = vld;
    assign pair_a       = a_q;
    assign pair_b       = b_q;
    assign pairs_issued = issued_q;
    assign err_unexp    = err_q;

endmodule

// File: tb/tb_pair_sched.sv
// tb_pair_sched: table-driven runs of pair_sched against a cycle model of the
// expected pair order, handshake, outstanding limit and completion timing,
// plus hand-written sequences for backpressure, mid-run start/reset and
// the sticky unexpected-result flag.
module tb_pair_sched;

    localparam int NUM_POINTS = 1000;
    localparam int MAX_OUT    = 8;
    localparam int IDX_W      = $clog2(NUM_POINTS);
    localparam int NPTS_W     = $clog2(NUM_POINTS + 1);
    localparam int PAIR_W     = $clog2(NUM_POINTS * (NUM_POINTS - 1) / 2 + 1);
    localparam int BUDGET     = 3000;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [NPTS_W-1:0] num_pts;
    logic              busy;
    logic [IDX_W-1:0]  pair_a;
    logic [IDX_W-1:0]  pair_b;
    logic              pair_vld;
    logic              pair_rdy;
    logic              res_vld;
    logic              dist_done;
    logic [PAIR_W-1:0] pairs_issued;
    logic              err_unexp;
    logic [31:0]       stall_cycles;

    always #5 clk = ~clk;

    pair_sched #(.NUM_POINTS(NUM_POINTS), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .num_pts     (num_pts),
        .busy        (busy),
        .pair_a      (pair_a),
        .pair_b      (pair_b),
        .pair_vld    (pair_vld),
        .pair_rdy    (pair_rdy),
        .res_vld     (res_vld),
        .dist_done   (dist_done),
        .pairs_issued(pairs_issued),
        .err_unexp   (err_unexp),
        .stall_cycles(stall_cycles)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference model state
    bit m_active;
    bit m_err;
    int m_n, m_total, m_issued, m_out, m_a, m_b, m_stall;
    int due[$];
    bit hold;
    int delay;

    typedef struct {
        int n;
        int mode;      // 0: rdy always high, 1: rdy high on odd cycles
        int dly;       // result latency in cycles
        int exp_pairs;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic model_reset();
        m_active = 0;
        m_n = 0; m_total = 0; m_issued = 0; m_out = 0;
        m_a = 0; m_b = 1; m_stall = 0;
        due.delete();
    endtask

    function automatic int exp_stall();
`ifdef PAIR_SCHED_PERF_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_dist_done"}, dist_done, 0);
        check({tag, "_pair_vld"}, pair_vld, 0);
        check({tag, "_pair_a"}, pair_a, 0);
        check({tag, "_pair_b"}, pair_b, 0);
        check({tag, "_pairs_issued"}, pairs_issued, 0);
        check({tag, "_err_unexp"}, err_unexp, 0);
        check({tag, "_stall_cycles"}, stall_cycles, 0);
    endtask

    // Compare outputs with the model, then apply one cycle of stimulus.
    task automatic drive_cycle(input bit rdy, input bit strt, input int np,
                               input bit force_res, input bit rel);
        bit mdone, evld, issuing, xfer, res;
        int n;
        mdone   = m_active && (m_issued == m_total) && (m_out == 0);
        evld    = m_active && (m_issued < m_total) && (m_out < MAX_OUT);
        issuing = m_active && (m_issued < m_total);
        check("busy", busy, m_active && !mdone);
        check("dist_done", dist_done, mdone);
        check("pair_vld", pair_vld, evld);
        if (evld) begin
            check("pair_a", pair_a, m_a);
            check("pair_b", pair_b, m_b);
        end
        check("pairs_issued", pairs_issued, m_issued);
        check("err_unexp", err_unexp, m_err);
        check("stall_cycles", stall_cycles, exp_stall());

        xfer = evld && rdy;
        res  = 0;
        if (force_res) res = 1;
        else if ((!hold || rel) && due.size() > 0 && due[0] <= cyc) begin
            res = 1;
            void'(due.pop_front());
        end
        if (issuing && ((evld && !rdy) || m_out == MAX_OUT)) m_stall++;
        if (res && m_out == 0 && !xfer) m_err = 1;
        m_out = m_out + (xfer ? 1 : 0) - ((res && (m_out != 0 || xfer)) ? 1 : 0);
        if (xfer) begin
            m_issued++;
            due.push_back(cyc + delay);
            if (m_b == m_n - 1) begin
                m_a++;
                m_b = m_a + 1;
            end else begin
                m_b++;
            end
        end
        if (strt && !(m_active && !mdone)) begin
            n = (np > NUM_POINTS) ? NUM_POINTS : np;
            model_reset();
            m_active = 1;
            m_n      = n;
            m_total  = n * (n - 1) / 2;
        end

        pair_rdy = rdy;
        res_vld  = res;
        start    = strt;
        num_pts  = NPTS_W'(np);
        tick();
        start    = 0;
    endtask

    task automatic finish_run(input int mode, input int exp_pairs);
        int guard;
        bit rdy;
        guard = 0;
        while (!((m_issued == m_total) && (m_out == 0)) && guard < BUDGET) begin
            rdy = (mode == 0) ? 1'b1 : cyc[0];
            drive_cycle(rdy, 0, 0, 0, 0);
            guard++;
        end
        n_checks++;
        if (guard >= BUDGET) begin
            n_fail++;
            $display("FAIL run_timeout: got %0d cycles expected fewer than %0d", guard, BUDGET);
        end
        drive_cycle(1, 0, 0, 0, 0);   // first DONE cycle
        drive_cycle(1, 0, 0, 0, 0);   // DONE held
        check("run_pairs", pairs_issued, exp_pairs);
        check("run_done", dist_done, 1);
    endtask

    task automatic run_vec(input vec_t v);
        delay = v.dly;
        hold  = 0;
        drive_cycle(0, 1, v.n, 0, 0);
        finish_run(v.mode, v.exp_pairs);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{n: 4,  mode: 0, dly: 4,  exp_pairs: 6};
        vecs[1] = '{n: 5,  mode: 1, dly: 2,  exp_pairs: 10};
        vecs[2] = '{n: 0,  mode: 0, dly: 1,  exp_pairs: 0};
        vecs[3] = '{n: 1,  mode: 0, dly: 1,  exp_pairs: 0};
        vecs[4] = '{n: 2,  mode: 1, dly: 3,  exp_pairs: 1};
        vecs[5] = '{n: 12, mode: 0, dly: 10, exp_pairs: 66};
        vecs[6] = '{n: 7,  mode: 1, dly: 1,  exp_pairs: 21};

        rst_n = 0; start = 0; num_pts = '0; pair_rdy = 0; res_vld = 0;
        hold = 0; delay = 1; m_err = 0;
        model_reset();
        tick();
        tick();
        check_zero("reset");
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // results withheld: in-flight cap stops issue at MAX_OUT
        delay = 1;
        hold  = 1;
        drive_cycle(1, 1, 10, 0, 0);
        repeat (14) drive_cycle(1, 0, 0, 0, 0);
        check("hold_transfers", pairs_issued, 8);
        check("hold_vld", pair_vld, 0);
        drive_cycle(1, 0, 0, 0, 1);
        repeat (4) drive_cycle(1, 0, 0, 0, 0);
        check("one_more_transfer", pairs_issued, 9);
        check("one_more_vld", pair_vld, 0);
        hold = 0;
        finish_run(0, 45);

        // start while busy is ignored
        delay = 3;
        drive_cycle(1, 1, 6, 0, 0);
        repeat (3) drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(1, 1, 2, 0, 0);
        finish_run(0, 15);

        // reset in the middle of a run
        drive_cycle(1, 1, 8, 0, 0);
        repeat (3) drive_cycle(1, 0, 0, 0, 0);
        check("pre_reset_busy", busy, 1);
        rst_n = 0; pair_rdy = 1; res_vld = 0;
        tick();
        check_zero("midreset");
        model_reset();
        m_err = 0;
        rst_n = 1;
        drive_cycle(1, 1, 3, 0, 0);
        check("restart_a", pair_a, 0);
        check("restart_b", pair_b, 1);
        finish_run(0, 3);

        // unexpected result in IDLE sets a flag that survives later runs
        rst_n = 0;
        tick();
        model_reset();
        rst_n = 1;
        drive_cycle(0, 0, 0, 1, 0);
        drive_cycle(0, 0, 0, 0, 0);
        check("err_idle", err_unexp, 1);
        delay = 1;
        drive_cycle(0, 1, 2, 0, 0);
        finish_run(0, 1);
        check("err_sticky", err_unexp, 1);
        rst_n = 0;
        tick();
        check("err_reset", err_unexp, 0);
        rst_n = 1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pair_sched.md
Name: pair_sched

Overview:
Scheduler that feeds the distance/sort datapath for one run of the circuit-connection solver. On start it enumerates every unordered point pair (a,b) with a<b exactly once and issues each pair to the distance unit over a valid/ready handshake. It limits the number of pairs in flight and counts returning distance results. When every issued pair has returned, it raises dist_done, which the insert sorter uses to begin read-out.

Parameters:
NUM_POINTS, 1000, maximum point count; sets index width IDX_W = $clog2(NUM_POINTS)
MAX_OUT, 8, maximum pairs issued but not yet returned by the distance unit
PAIR_W, $clog2(NUM_POINTS*(NUM_POINTS-1)/2+1), width of the pair counter (derived; never overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle run request; honoured only in IDLE or DONE
num_pts  in  $clog2(NUM_POINTS+1)  point count for the run; sampled on the accepted start
busy  out  1  high in ISSUE or DRAIN
pair_a  out  IDX_W  lower index of the offered pair
pair_b  out  IDX_W  higher index of the offered pair
pair_vld  out  1  offered pair is valid
pair_rdy  in  1  distance unit accepts the pair
res_vld  in  1  one distance result returned to the sorter this cycle
dist_done  out  1  all pairs issued and all results returned
pairs_issued  out  PAIR_W  pairs transferred in the current run
err_unexp  out  1  sticky flag: res_vld seen while outstanding==0
stall_cycles  out  32  performance counter; see Optional Feature

Behaviour:
- Reset (rst_n low at clk edge), including mid-run:
  - state=IDLE; all outputs 0.
  - Outstanding count, pairs_issued, err_unexp and stall_cycles cleared.
- States:
  - IDLE: waits for start.
  - ISSUE: offers pairs.
  - DRAIN: waits for outstanding results.
  - DONE: dist_done=1, held until the next accepted start or reset.
- Start handling:
  - Accepted start loads n = min(num_pts, NUM_POINTS), sets a=0, b=1 and clears pairs_issued and outstanding. err_unexp is not cleared.
  - If n<2: go to DONE on the next cycle with zero pairs.
  - Otherwise go to ISSUE. pair_vld is high with (0,1) the cycle after start.
  - start while busy is ignored.
- Pair order: b increments fastest. After (a, n-1) comes (a+1, a+2). The last pair is (n-2, n-1). Total pairs = n*(n-1)/2.
- Handshake:
  - Transfer occurs on a cycle with pair_vld && pair_rdy.
  - pair_a/pair_b hold stable while pair_vld && !pair_rdy.
  - pair_vld = (state==ISSUE) && (outstanding < MAX_OUT). Once asserted it cannot fall before a transfer, because outstanding only rises on a transfer.
- Outstanding count:
  - outstanding_next = outstanding + transfer − (res_vld && (outstanding!=0 || transfer)).
  - A transfer and a result in the same cycle leave the count unchanged.
  - res_vld with outstanding==0 and no transfer is dropped and sets err_unexp.
- pairs_issued increments on each transfer.
- State transitions after the last pair transfers:
  - ISSUE→DRAIN when the last pair transfers and outstanding_next != 0.
  - ISSUE→DONE directly when outstanding_next == 0.
  - DRAIN→DONE when outstanding_next == 0.
- dist_done timing: dist_done is a registered output, high in every DONE cycle. The first high cycle is the cycle after the final result returns.
- Start from DONE: the next cycle dist_done=0, busy=1 and a new run begins.

Optional Feature:
PAIR_SCHED_PERF_EN:
- Defined: stall_cycles increments (saturating at 2^32−1) on each ISSUE cycle where pair_vld && !pair_rdy, or where outstanding==MAX_OUT. It is cleared on reset and on an accepted start.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- n=4, pair_rdy=1, res_vld returned 4 cycles after each transfer -> pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) on consecutive cycles; pairs_issued=6; dist_done rises the cycle after the 6th result.
- n=5, pair_rdy toggling every cycle -> pair_a/b stable while stalled; 10 unique pairs; with PERF_EN, stall_cycles = number of rdy-low ISSUE cycles.
- n=10, res_vld withheld -> exactly 8 transfers, then pair_vld=0; one res_vld -> exactly one more transfer; release all results -> 45 pairs, then DONE.
- n=1, and separately n=0 -> DONE one cycle after start; pair_vld never high; pairs_issued=0.
- start pulsed mid-ISSUE -> ignored, sequence unaltered; rst_n low mid-ISSUE -> next cycle all outputs 0, state IDLE; a following start restarts at (0,1).
- res_vld while IDLE -> err_unexp=1 and stays 1 across a later start; cleared only by reset.
